// File: rtl/mem_access_stage.sv
// mem_access_stage: single-entry load/store stage between execute and writeback
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_allow,
   input  logic [31:0]       in_pc,
   input  logic [3:0]        in_mem_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [3:0]        in_rf_we,
   input  logic [4:0]        in_rf_waddr,
   input  logic [DATA_W-1:0] in_rf_wdata,
   input  logic              flush,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_wr,
   output logic [BE_W-1:0]   req_be,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              resp_valid,
   input  logic [DATA_W-1:0] resp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [3:0]        out_rf_we,
   output logic [4:0]        out_rf_waddr,
   output logic [DATA_W-1:0] out_rf_wdata,
   output logic              out_ex_ale,
   output logic [ADDR_W-1:0] out_badv
);

   localparam int LG = $clog2(BE_W);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} state_t;

   // {memory op, load, sign-extend, log2 size}; doubleword ops only exist on a 64-bit datapath
   function automatic logic [4:0] decode(input logic [3:0] op);
      logic w64;
      w64 = (DATA_W == 64);
      case (op)
         4'b0000: decode = 5'b111_00;
         4'b0001: decode = 5'b111_01;
         4'b0010: decode = 5'b111_10;
         4'b0011: decode = w64 ? 5'b111_11 : 5'b000_00;
         4'b1000: decode = 5'b110_00;
         4'b1001: decode = 5'b110_01;
         4'b0100: decode = 5'b100_00;
         4'b0101: decode = 5'b100_01;
         4'b0110: decode = 5'b100_10;
         4'b0111: decode = w64 ? 5'b100_11 : 5'b000_00;
         default: decode = 5'b000_00;
      endcase
   endfunction

   state_t            state_q, state_d, cap_state;
   logic [31:0]       pc_q, pc_d;
   logic [4:0]        dec_q, dec_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              ale_q, ale_d;

   logic [4:0]        in_dec;
   logic              in_mis, cap, is_load, is_store, op_sgn;
   logic [1:0]        op_size;
   logic [LG-1:0]     lane;
   logic [BE_W-1:0]   be_mask;
   logic [DATA_W-1:0] shifted, ld_val, wdata_rep;

   // decode incoming and held ops; capture happens only when the stage can accept and no flush is pending
   always_comb begin
      in_dec    = decode(in_mem_op);
      in_mis    = in_dec[4] & |(in_addr[2:0] & (3'b111 >> (2'd3 - in_dec[1:0])));
      in_allow  = ((state_q == IDLE) | ((state_q == DONE) & out_ready)) & ~flush;
      cap       = in_valid & in_allow;
      cap_state = (in_dec[4] & ~in_mis) ? REQ : DONE;
      is_load   = dec_q[4] & dec_q[3];
      is_store  = dec_q[4] & ~dec_q[3];
      op_sgn    = dec_q[2];
      op_size   = dec_q[1:0];
      lane      = addr_q[LG-1:0];
   end

   // byte-lane steering for stores and lane extraction/extension for loads
   always_comb begin
      be_mask   = op_size == 2'd0 ? BE_W'(1) : op_size == 2'd1 ? BE_W'(3) : op_size == 2'd2 ? BE_W'(15) : '1;
      wdata_rep = op_size == 2'd0 ? {BE_W{wdata_q[7:0]}} :
                  op_size == 2'd1 ? {(BE_W/2){wdata_q[15:0]}} :
                  op_size == 2'd2 ? {(BE_W/4){wdata_q[31:0]}} : wdata_q;
      shifted   = resp_rdata >> {lane, 3'b000};
      ld_val    = op_size == 2'd0 ? (op_sgn ? DATA_W'($signed(shifted[7:0])) : DATA_W'(shifted[7:0])) :
                  op_size == 2'd1 ? (op_sgn ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0])) :
                  op_size == 2'd2 ? (op_sgn ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0])) : shifted;
   end

   // next state; flush wins over every handshake, and a flushed load must still swallow its response
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = cap ? cap_state : IDLE;
         REQ:     state_d = flush ? IDLE : req_ready ? (is_load ? WAIT : DONE) : REQ;
         WAIT:    state_d = flush ? (resp_valid ? IDLE : CANCEL) : resp_valid ? DONE : WAIT;
         DONE:    state_d = flush ? IDLE : cap ? cap_state : out_ready ? IDLE : DONE;
         CANCEL:  state_d = resp_valid ? IDLE : CANCEL;
         default: state_d = IDLE;
      endcase
   end

   // held instruction fields; load data replaces the forwarded rf_wdata when the response lands
   always_comb begin
      pc_d       = cap ? in_pc : pc_q;
      dec_d      = cap ? in_dec : dec_q;
      addr_d     = cap ? in_addr : addr_q;
      wdata_d    = cap ? in_wdata : wdata_q;
      rf_we_d    = cap ? in_rf_we : rf_we_q;
      rf_waddr_d = cap ? in_rf_waddr : rf_waddr_q;
      rf_wdata_d = cap ? in_rf_wdata : ((state_q == WAIT) & resp_valid & ~flush) ? ld_val : rf_wdata_q;
      ale_d      = cap ? in_mis : ale_q;
   end

   // state and held fields; reset drops any transaction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         dec_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rf_we_q    <= '0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         ale_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dec_q      <= dec_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         ale_q      <= ale_d;
      end
   end

   // outputs; valids are withdrawn under flush so a cancelled op never completes a handshake
   always_comb begin
      req_valid    = (state_q == REQ) & ~flush;
      req_wr       = is_store;
      req_be       = is_store ? (be_mask << lane) : '0;
      req_addr     = addr_q;
      req_wdata    = wdata_rep;
      out_valid    = (state_q == DONE) & ~flush;
      out_pc       = pc_q;
      out_rf_we    = (ale_q | is_store) ? 4'b0 : rf_we_q;
      out_rf_waddr = rf_waddr_q;
      out_rf_wdata = rf_wdata_q;
      out_ex_ale   = ale_q;
      out_badv     = ale_q ? addr_q : '0;
   end

endmodule
